// File: rtl/vc_fifo_pkg.sv
// Shared defaults and helpers for the virtual-channel FIFO bank.
package vc_fifo_pkg;

    localparam int VC_BW_DEF    = 6;
    localparam int VC_DEPTH_DEF = 4;
    localparam int VC_NVC_DEF   = 4;

    // Width of a channel index; never collapses to zero bits.
    function automatic int vc_idx_w(input int nvc);
        return (nvc > 1) ? $clog2(nvc) : 1;
    endfunction

endpackage

// File: rtl/vc_rr_arbiter.sv
// Pop arbiter for the VC FIFO bank: round-robin by default,
// strict highest-index priority when VC_FIFO_PRIO_EN is defined.
module vc_rr_arbiter
    import vc_fifo_pkg::*;
#(
    parameter int NVC = VC_NVC_DEF,
    parameter int VW  = vc_idx_w(NVC)
) (
    input  logic [NVC-1:0] req,
    input  logic [VW-1:0]  last_ptr,
    input  logic           pop_en,
    output logic [VW-1:0]  gnt_idx,
    output logic           gnt_vld
);

    logic found;

`ifdef VC_FIFO_PRIO_EN
    logic unused_last;
    assign unused_last = ^last_ptr;

    always_comb begin
        gnt_idx = '0;
        found   = 1'b0;
        for (int i = NVC - 1; i >= 0; i--) begin
            if (!found && req[i]) begin
                found   = 1'b1;
                gnt_idx = VW'(i);
            end
        end
        gnt_vld = found && pop_en;
    end
`else
    logic [VW-1:0] idx;

    // Walk upward from the channel after the last one served, wrapping at NVC-1.
    always_comb begin
        gnt_idx = '0;
        found   = 1'b0;
        idx     = last_ptr;
        for (int i = 0; i < NVC; i++) begin
            idx = (idx == VW'(NVC - 1)) ? '0 : idx + VW'(1);
            if (!found && req[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
        gnt_vld = found && pop_en;
    end
`endif

endmodule

// File: rtl/vc_fifo_bank.sv
// Bank of NVC independent circular FIFOs sharing one arbitrated pop port.
// Build option: VC_FIFO_PRIO_EN selects strict priority arbitration.
module vc_fifo_bank
    import vc_fifo_pkg::*;
#(
    parameter int BW    = VC_BW_DEF,
    parameter int DEPTH = VC_DEPTH_DEF,
    parameter int NVC   = VC_NVC_DEF,
    parameter int AW    = $clog2(DEPTH) + 1,
    localparam int VW   = vc_idx_w(NVC)
) (
    input  logic           clk,
    input  logic           reset_L,
    input  logic           wr,
    input  logic [VW-1:0]  wr_vc,
    input  logic [BW-1:0]  data_in,
    input  logic           rd,
    input  logic [AW-1:0]  umbral_bajo,
    input  logic [AW-1:0]  umbral_alto,
    output logic [BW-1:0]  data_out,
    output logic [VW-1:0]  data_vc,
    output logic           valid,
    output logic [NVC-1:0] full,
    output logic [NVC-1:0] empty,
    output logic [NVC-1:0] almost_full,
    output logic [NVC-1:0] almost_empty,
    output logic           pause,
    output logic [NVC-1:0] error_output
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [AW-1:0] CNT_FULL = AW'(DEPTH);

    logic [BW-1:0]  mem_q    [NVC][DEPTH];
    logic [PW-1:0]  wr_ptr_q [NVC];
    logic [PW-1:0]  wr_ptr_d [NVC];
    logic [PW-1:0]  rd_ptr_q [NVC];
    logic [PW-1:0]  rd_ptr_d [NVC];
    logic [AW-1:0]  cnt_q    [NVC];
    logic [AW-1:0]  cnt_d    [NVC];
    logic [NVC-1:0] err_q, err_d;
    logic [NVC-1:0] req, wr_sel, pop_sel, accept;
    logic [VW-1:0]  last_q, gnt_idx;
    logic           gnt_vld;
    logic [BW-1:0]  dout_q;
    logic [VW-1:0]  dvc_q;
    logic           valid_q;

    // Requests come from registered occupancy, so a same-cycle write is never popped.
    always_comb begin
        for (int v = 0; v < NVC; v++) begin
            req[v] = (cnt_q[v] != '0);
        end
    end

    vc_rr_arbiter #(
        .NVC (NVC),
        .VW  (VW)
    ) u_arb (
        .req      (req),
        .last_ptr (last_q),
        .pop_en   (rd),
        .gnt_idx  (gnt_idx),
        .gnt_vld  (gnt_vld)
    );

    // A full channel still accepts a write when it is being popped in the same cycle.
    always_comb begin
        for (int v = 0; v < NVC; v++) begin
            wr_sel[v]  = wr && (wr_vc == VW'(v));
            pop_sel[v] = gnt_vld && (gnt_idx == VW'(v));
            accept[v]  = wr_sel[v] && ((cnt_q[v] != CNT_FULL) || pop_sel[v]);
        end
    end

    always_comb begin
        err_d = err_q;
        if (rd && !gnt_vld) begin
            err_d[0] = 1'b1;
        end
        for (int v = 0; v < NVC; v++) begin
            wr_ptr_d[v] = wr_ptr_q[v];
            rd_ptr_d[v] = rd_ptr_q[v];
            cnt_d[v]    = cnt_q[v];
            if (accept[v]) begin
                wr_ptr_d[v] = wr_ptr_q[v] + PW'(1);
            end
            if (wr_sel[v] && !accept[v]) begin
                err_d[v] = 1'b1;
            end
            if (pop_sel[v]) begin
                rd_ptr_d[v] = rd_ptr_q[v] + PW'(1);
            end
            case ({accept[v], pop_sel[v]})
                2'b10:   cnt_d[v] = cnt_q[v] + AW'(1);
                2'b01:   cnt_d[v] = cnt_q[v] - AW'(1);
                default: cnt_d[v] = cnt_q[v];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            for (int v = 0; v < NVC; v++) begin
                wr_ptr_q[v] <= '0;
                rd_ptr_q[v] <= '0;
                cnt_q[v]    <= '0;
            end
            err_q   <= '0;
            last_q  <= VW'(NVC - 1);
            dout_q  <= '0;
            dvc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            for (int v = 0; v < NVC; v++) begin
                wr_ptr_q[v] <= wr_ptr_d[v];
                rd_ptr_q[v] <= rd_ptr_d[v];
                cnt_q[v]    <= cnt_d[v];
            end
            err_q   <= err_d;
            valid_q <= gnt_vld;
            if (gnt_vld) begin
                dout_q <= mem_q[gnt_idx][rd_ptr_q[gnt_idx]];
                dvc_q  <= gnt_idx;
                last_q <= gnt_idx;
            end
        end
    end

    // Storage is deliberately left unreset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        for (int v = 0; v < NVC; v++) begin
            if (reset_L && accept[v]) begin
                mem_q[v][wr_ptr_q[v]] <= data_in;
            end
        end
    end

    always_comb begin
        for (int v = 0; v < NVC; v++) begin
            full[v]         = (cnt_q[v] == CNT_FULL);
            empty[v]        = (cnt_q[v] == '0);
            almost_full[v]  = (cnt_q[v] >= umbral_alto);
            almost_empty[v] = (cnt_q[v] <= umbral_bajo);
        end
    end

    assign pause        = |almost_full;
    assign data_out     = dout_q;
    assign data_vc      = dvc_q;
    assign valid        = valid_q;
    assign error_output = err_q;

endmodule

// File: tb/tb_vc_fifo_bank.sv
// Bench for vc_fifo_bank: hand-computed vector table, directed corner sequences,
// and a queue-based reference model with a pop scoreboard for random traffic.
module tb_vc_fifo_bank;

    localparam int BW    = 6;
    localparam int DEPTH = 4;
    localparam int NVC   = 4;
    localparam int AW    = 3;
    localparam int VW    = 2;

    logic           clk = 1'b0;
    logic           reset_L, wr, rd;
    logic [VW-1:0]  wr_vc;
    logic [BW-1:0]  data_in;
    logic [AW-1:0]  umbral_bajo, umbral_alto;
    logic [BW-1:0]  data_out;
    logic [VW-1:0]  data_vc;
    logic           valid, pause;
    logic [NVC-1:0] full, empty, almost_full, almost_empty, error_output;

    vc_fifo_bank #(.BW(BW), .DEPTH(DEPTH), .NVC(NVC), .AW(AW)) dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .wr           (wr),
        .wr_vc        (wr_vc),
        .data_in      (data_in),
        .rd           (rd),
        .umbral_bajo  (umbral_bajo),
        .umbral_alto  (umbral_alto),
        .data_out     (data_out),
        .data_vc      (data_vc),
        .valid        (valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .pause        (pause),
        .error_output (error_output)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: one queue of words per channel plus a pop scoreboard.
    typedef struct {
        logic [VW-1:0] vc;
        logic [BW-1:0] d;
    } sb_t;

    logic [BW-1:0]  mq [NVC][$];
    sb_t            sb [$];
    int             m_last = NVC - 1;
    logic [NVC-1:0] m_err  = '0;
    logic [BW-1:0]  m_dout = '0;

    function automatic int model_pick();
`ifdef VC_FIFO_PRIO_EN
        for (int v = NVC - 1; v >= 0; v--)
            if (mq[v].size() > 0) return v;
`else
        for (int i = 1; i <= NVC; i++)
            if (mq[(m_last + i) % NVC].size() > 0) return (m_last + i) % NVC;
`endif
        return -1;
    endfunction

    task automatic apply(input logic rst_n, input logic w, input int vc, input int d, input logic r);
        int  pv;
        sb_t e;
        logic [NVC-1:0] x_empty, x_full;
        reset_L = rst_n;
        wr      = w;
        wr_vc   = VW'(vc);
        data_in = BW'(d);
        rd      = r;
        if (!rst_n) begin
            for (int v = 0; v < NVC; v++) mq[v].delete();
            sb.delete();
            m_last = NVC - 1;
            m_err  = '0;
            m_dout = '0;
        end else begin
            if (r) begin
                pv = model_pick();
                if (pv >= 0) begin
                    e.vc = VW'(pv);
                    e.d  = mq[pv].pop_front();
                    sb.push_back(e);
                    m_last = pv;
                end else begin
                    m_err[0] = 1'b1;
                end
            end
            if (w) begin
                if (mq[vc].size() < DEPTH) mq[vc].push_back(BW'(d));
                else m_err[vc] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            m_dout = e.d;
            chk("sb_valid", valid, 1);
            chk("sb_data", data_out, e.d);
            chk("sb_vc", data_vc, e.vc);
        end else begin
            chk("sb_idle_valid", valid, 0);
            chk("sb_data_hold", data_out, m_dout);
        end
        for (int v = 0; v < NVC; v++) begin
            x_empty[v] = (mq[v].size() == 0);
            x_full[v]  = (mq[v].size() == DEPTH);
        end
        chk("model_empty", empty, x_empty);
        chk("model_full", full, x_full);
        chk("model_err", error_output, m_err);
    endtask

    typedef struct {
        logic rst_n, w;
        int   vc, d;
        logic r;
        logic [3:0] e_empty, e_full, e_af, e_ae, e_err;
        int   e_vc;
    } vec_t;

    vec_t tv[$];

    task automatic addv(input logic rst_n, w, input int vc, d, input logic r,
                        input logic [3:0] ee, ef, eaf, eae, eerr, input int evc);
        vec_t t;
        t = '{rst_n, w, vc, d, r, ee, ef, eaf, eae, eerr, evc};
        tv.push_back(t);
    endtask

    initial begin
        reset_L = 1'b0; wr = 1'b0; rd = 1'b0; wr_vc = '0; data_in = '0;
        umbral_bajo = 3'd1;
        umbral_alto = 3'd3;

        //   rst w vc d     r  empty    full     af       ae       err      vc
        addv(0, 0, 0, 0,    0, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b0000, -1);
        addv(1, 1, 2, 'h01, 0, 4'b1011, 4'b0000, 4'b0000, 4'b1111, 4'b0000, -1);
        addv(1, 1, 2, 'h02, 0, 4'b1011, 4'b0000, 4'b0000, 4'b1011, 4'b0000, -1);
        addv(1, 1, 2, 'h03, 0, 4'b1011, 4'b0000, 4'b0100, 4'b1011, 4'b0000, -1);
        addv(1, 1, 2, 'h04, 0, 4'b1011, 4'b0100, 4'b0100, 4'b1011, 4'b0000, -1);
        addv(1, 1, 2, 'h05, 0, 4'b1011, 4'b0100, 4'b0100, 4'b1011, 4'b0100, -1);
        addv(1, 0, 0, 0,    1, 4'b1011, 4'b0000, 4'b0100, 4'b1011, 4'b0100,  2);
        addv(1, 1, 2, 'h06, 1, 4'b1011, 4'b0000, 4'b0100, 4'b1011, 4'b0100,  2);
        addv(1, 0, 0, 0,    1, 4'b1011, 4'b0000, 4'b0000, 4'b1011, 4'b0100,  2);
        addv(1, 0, 0, 0,    1, 4'b1011, 4'b0000, 4'b0000, 4'b1111, 4'b0100,  2);
        addv(1, 0, 0, 0,    1, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b0100,  2);
        addv(1, 0, 0, 0,    1, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b0101, -1);
        addv(0, 0, 0, 0,    0, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b0000, -1);
        addv(1, 1, 0, 'h0A, 0, 4'b1110, 4'b0000, 4'b0000, 4'b1111, 4'b0000, -1);
        addv(1, 1, 1, 'h0B, 0, 4'b1100, 4'b0000, 4'b0000, 4'b1111, 4'b0000, -1);
        addv(1, 1, 2, 'h0C, 0, 4'b1000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, -1);
        addv(1, 1, 3, 'h0D, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, -1);
`ifdef VC_FIFO_PRIO_EN
        addv(1, 0, 0, 0,    1, 4'b1000, 4'b0000, 4'b0000, 4'b1111, 4'b0000,  3);
        addv(1, 0, 0, 0,    1, 4'b1100, 4'b0000, 4'b0000, 4'b1111, 4'b0000,  2);
        addv(1, 0, 0, 0,    1, 4'b1110, 4'b0000, 4'b0000, 4'b1111, 4'b0000,  1);
        addv(1, 0, 0, 0,    1, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b0000,  0);
`else
        addv(1, 0, 0, 0,    1, 4'b0001, 4'b0000, 4'b0000, 4'b1111, 4'b0000,  0);
        addv(1, 0, 0, 0,    1, 4'b0011, 4'b0000, 4'b0000, 4'b1111, 4'b0000,  1);
        addv(1, 0, 0, 0,    1, 4'b0111, 4'b0000, 4'b0000, 4'b1111, 4'b0000,  2);
        addv(1, 0, 0, 0,    1, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b0000,  3);
`endif
        addv(1, 0, 0, 0,    0, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b0000, -1);

        for (int i = 0; i < tv.size(); i++) begin
            apply(tv[i].rst_n, tv[i].w, tv[i].vc, tv[i].d, tv[i].r);
            chk($sformatf("tv%0d_empty", i), empty, tv[i].e_empty);
            chk($sformatf("tv%0d_full", i), full, tv[i].e_full);
            chk($sformatf("tv%0d_afull", i), almost_full, tv[i].e_af);
            chk($sformatf("tv%0d_aempty", i), almost_empty, tv[i].e_ae);
            chk($sformatf("tv%0d_pause", i), pause, |tv[i].e_af);
            chk($sformatf("tv%0d_err", i), error_output, tv[i].e_err);
            chk($sformatf("tv%0d_valid", i), valid, tv[i].e_vc >= 0);
            if (tv[i].e_vc >= 0) chk($sformatf("tv%0d_vc", i), data_vc, tv[i].e_vc);
        end

        // Threshold of zero makes every empty channel almost-full.
        umbral_alto = 3'd0;
        #1 chk("pause_thr0", pause, 1);
        umbral_alto = 3'd3;
        #1 chk("pause_thr3", pause, 0);

        // Full VC1 written and popped in the same cycle.
        apply(0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) apply(1, 1, 1, 'h21 + k, 0);
        chk("full1_before", full[1], 1);
        apply(1, 1, 1, 'h25, 1);
        chk("wrpop_full1", full[1], 1);
        chk("wrpop_err1", error_output[1], 0);
        chk("wrpop_vc", data_vc, 1);
        chk("wrpop_data", data_out, 'h21);
        for (int k = 0; k < 4; k++) apply(1, 0, 0, 0, 1);
        chk("drain_last", data_out, 'h25);

        // Pop from an all-empty bank, then write VC0 together with rd (no bypass).
        apply(1, 0, 0, 0, 1);
        chk("empty_rd_valid", valid, 0);
        chk("empty_rd_err0", error_output[0], 1);
        apply(1, 1, 0, 'h30, 1);
        chk("nobypass_valid", valid, 0);
        chk("nobypass_empty0", empty[0], 0);
        chk("nobypass_ae0", almost_empty[0], 1);
        apply(1, 0, 0, 0, 1);
        chk("nobypass_pop", data_out, 'h30);

        // Reset mid-operation with VC3 holding two words; wr/rd in that cycle ignored.
        apply(0, 0, 0, 0, 0);
        apply(1, 1, 3, 'h31, 0);
        apply(1, 1, 3, 'h32, 0);
        chk("vc3_two", empty[3], 0);
        apply(0, 1, 3, 'h3F, 1);
        chk("rst_empty3", empty[3], 1);
        chk("rst_valid", valid, 0);
        chk("rst_err", error_output, 0);
        apply(1, 0, 0, 0, 0);
        chk("rst_after_empty", empty, 4'b1111);

        // Random traffic checked against the reference model.
        for (int n = 0; n < 400; n++) begin
            apply($urandom_range(0, 49) != 0, $urandom_range(0, 1), $urandom_range(0, NVC - 1),
                  $urandom_range(0, 63), $urandom_range(0, 2) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
